// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a single combinational ALU
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_srca_0,
  input  logic [WIDTH-1:0] req_srcb_0,
  input  logic [2:0]       req_aluctrl_0,
  input  logic [2:0]       req_aluop_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_result_0,
  output logic             rsp_branch_0,
  output logic             rsp_carry_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_srca_1,
  input  logic [WIDTH-1:0] req_srcb_1,
  input  logic [2:0]       req_aluctrl_1,
  input  logic [2:0]       req_aluop_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_result_1,
  output logic             rsp_branch_1,
  output logic             rsp_carry_1,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [2:0]       alu_aluctrl,
  output logic [2:0]       alu_aluop,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_branch,
  input  logic             alu_carry
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   owner;
  logic   any_valid;
  logic   pick1;
  logic   grant;

`ifdef ALU_ARB_RR_EN
  logic   ptr;
  // On conflict the pointed-to requester wins.
  always_comb pick1 = req_valid_1 && (!req_valid_0 || ptr);
`else
  always_comb pick1 = req_valid_1 && !req_valid_0;
`endif

  assign any_valid   = req_valid_0 | req_valid_1;
  assign grant       = (state == IDLE) && any_valid && !reset;
  assign req_ready_0 = grant && !pick1;
  assign req_ready_1 = grant && pick1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr          <= 1'b0;
`endif
      alu_srca     <= '0;
      alu_srcb     <= '0;
      alu_aluctrl  <= '0;
      alu_aluop    <= '0;
      rsp_valid_0  <= 1'b0;
      rsp_result_0 <= '0;
      rsp_branch_0 <= 1'b0;
      rsp_carry_0  <= 1'b0;
      rsp_valid_1  <= 1'b0;
      rsp_result_1 <= '0;
      rsp_branch_1 <= 1'b0;
      rsp_carry_1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner <= pick1;
`ifdef ALU_ARB_RR_EN
            ptr   <= !pick1;
`endif
            if (pick1) begin
              alu_srca    <= req_srca_1;
              alu_srcb    <= req_srcb_1;
              alu_aluctrl <= req_aluctrl_1;
              alu_aluop   <= req_aluop_1;
            end else begin
              alu_srca    <= req_srca_0;
              alu_srcb    <= req_srcb_0;
              alu_aluctrl <= req_aluctrl_0;
              alu_aluop   <= req_aluop_0;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has seen stable operands for a full cycle; steer its result to the owner only.
          rsp_valid_0  <= !owner;
          rsp_result_0 <= owner ? '0 : alu_result;
          rsp_branch_0 <= !owner && alu_branch;
          rsp_carry_0  <= !owner && alu_carry;
          rsp_valid_1  <= owner;
          rsp_result_1 <= owner ? alu_result : '0;
          rsp_branch_1 <= owner && alu_branch;
          rsp_carry_1  <= owner && alu_carry;
          state        <= RESP;
        end
        RESP: begin
          if (owner ? rsp_ready_1 : rsp_ready_0) begin
            rsp_valid_0  <= 1'b0;
            rsp_result_0 <= '0;
            rsp_branch_0 <= 1'b0;
            rsp_carry_0  <= 1'b0;
            rsp_valid_1  <= 1'b0;
            rsp_result_1 <= '0;
            rsp_branch_1 <= 1'b0;
            rsp_carry_1  <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports, per requester n in {0,1}: req_valid_n  input  1  operation request.
REQ-005 SHALL have ports: req_ready_n  output  1  request accepted this cycle.
REQ-006 SHALL have ports: req_srca_n, req_srcb_n  input  WIDTH  operands.
REQ-007 SHALL have ports: req_aluctrl_n  input  3  ALUControl code; req_aluop_n  input  3  ALUop code.
REQ-008 SHALL have ports: rsp_valid_n  output  1  result available; rsp_ready_n  input  1  result consumed.
REQ-009 SHALL have ports: rsp_result_n  output  WIDTH; rsp_branch_n  output  1; rsp_carry_n  output  1.
REQ-010 SHALL have ALU-side ports: alu_srca, alu_srcb  output  WIDTH; alu_aluctrl, alu_aluop  output  3.
REQ-011 SHALL have ALU-side ports: alu_result  input  WIDTH; alu_branch  input  1; alu_carry  input  1 (combinational ALU).

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-013 IDLE: if any req_valid_n high, SHALL assert req_ready_n of the granted requester only, combinationally, same cycle.
REQ-014 On grant SHALL latch operands, codes and owner id; next state EXEC.
REQ-015 alu_* outputs SHALL be driven from the latched registers at all times (stable through EXEC; hold last values otherwise).
REQ-016 EXEC: SHALL capture alu_result/alu_branch/alu_carry at cycle end; next state RESP.
REQ-017 RESP: SHALL assert rsp_valid of owner only, with captured values held stable until rsp_ready of owner high.
REQ-018 RESP with owner rsp_ready high SHALL go to IDLE next cycle; no new grant in that same cycle.
REQ-019 Minimum issue-to-issue spacing SHALL be 3 cycles; grant-to-rsp_valid latency exactly 2 cycles.
REQ-020 req_ready_n SHALL be low in EXEC and RESP regardless of req_valid.
REQ-021 Both valid in IDLE: winner SHALL be chosen per REQ-028/029.
REQ-022 rsp_* of the non-owner SHALL be 0; rsp_valid never asserted to both.
REQ-023 Requester dropping req_valid while not granted SHALL be ignored without error.
REQ-024 rsp_ready of non-owner SHALL be ignored.

Reset
REQ-025 reset high SHALL immediately force IDLE, all req_ready/rsp_valid 0, all rsp_* 0, alu_* 0, owner 0, priority pointer 0.
REQ-026 Reset during EXEC or RESP SHALL discard the in-flight operation; no response issued after reset release.
REQ-027 First grant SHALL be possible in the first clock edge with reset low.

Configuration
REQ-028 With ALU_ARB_RR_EN defined: round-robin; pointer starts at 0, after each grant points to the other requester; on conflict pointed requester wins.
REQ-029 Without ALU_ARB_RR_EN: fixed priority, requester 0 always wins conflicts; no pointer state.

Verification
REQ-030 Single req0 add (srca=5, srcb=7, aluop=000, aluctrl=000) -> req_ready_0 same cycle, rsp_valid_0 2 cycles later, rsp_result_0=12.
REQ-031 Both valid in IDLE, RR defined: req0 sub(10,3) and req1 xor(0xF0,0xFF) -> req0 first result 7, then req1 result 0x0F; RR undefined with req0 held valid repeatedly -> req1 starves.
REQ-032 Backpressure: rsp_ready_0 low 5 cycles -> rsp_valid_0 and rsp_result_0 stable 5 cycles, req_ready_1 low throughout, grant to req1 in cycle after rsp_ready_0 high.
REQ-033 reset asserted in EXEC -> outputs 0 immediately, no rsp_valid after release; new req1 add(1,1) -> result 2.
REQ-034 Back-to-back: req0 continuously valid, rsp_ready_0 tied high -> req_ready_0 exactly every 3rd cycle.
REQ-035 Branch op (aluop=010, srca=srcb=9) -> rsp_branch_n equals ALU model alu_branch, rsp_result_n=0.
